// File: rtl/rv_rr_arbiter.sv
// rv_rr_arbiter: round-robin arbiter merging N ready/valid sources into one
// registered downstream channel. A 1-entry output buffer refills in the
// same cycle it drains, so a source can move one beat per cycle.
// m_id records which source produced each buffered beat.
// Optional packet lock (define RV_ARB_LOCK_EN): once a multi-beat packet
// starts, the arbiter stays with that source until its s_last beat.

// Per-requester slice: request masking under lock and the ready decode.
module rv_rr_arb_lane #(
    parameter int ID_WIDTH = 1,
    parameter int IDX      = 0
) (
    input  logic                s_valid,
    input  logic                locked,
    input  logic [ID_WIDTH-1:0] lock_id,
    input  logic                grant_vld,
    input  logic [ID_WIDTH-1:0] grant_id,
    input  logic                load,
    output logic                req,
    output logic                ready
);
    // While locked, only the owning source may compete.
    assign req   = s_valid && (!locked || (lock_id == ID_WIDTH'(IDX)));
    assign ready = load && grant_vld && (grant_id == ID_WIDTH'(IDX));
endmodule

module rv_rr_arbiter #(
    parameter  int N          = 2,
    parameter  int DATA_WIDTH = 1,
    localparam int ID_WIDTH   = (N > 1) ? $clog2(N) : 1
) (
    input  logic                  clk,
    input  logic                  resetn,
    input  logic [N-1:0]          s_valid,
    input  logic [N*DATA_WIDTH-1:0] s_data,
`ifdef RV_ARB_LOCK_EN
    input  logic [N-1:0]          s_last,
    output logic                  m_last,
`endif
    output logic [N-1:0]          s_ready,
    output logic                  m_valid,
    output logic [DATA_WIDTH-1:0] m_data,
    output logic [ID_WIDTH-1:0]   m_id,
    input  logic                  m_ready
);

    logic [ID_WIDTH-1:0]   ptr;
    logic [ID_WIDTH-1:0]   grant_id;
    logic [ID_WIDTH-1:0]   nxt_ptr;
    logic                  grant_vld;
    logic                  load;
    logic                  locked;
    logic                  win_last;
    logic [N-1:0]          req;
    logic [DATA_WIDTH-1:0] win_data;

    // Buffer takes a new beat when empty or draining this cycle.
    assign load = !m_valid || m_ready;

    genvar gi;
    generate
        for (gi = 0; gi < N; gi++) begin : g_lane
            // The lock owner is always the source of the beat in the
            // buffer, since only it can be granted while locked.
            rv_rr_arb_lane #(.ID_WIDTH(ID_WIDTH), .IDX(gi)) u_lane (
                .s_valid   (s_valid[gi]),
                .locked    (locked),
                .lock_id   (m_id),
                .grant_vld (grant_vld),
                .grant_id  (grant_id),
                .load      (load),
                .req       (req[gi]),
                .ready     (s_ready[gi])
            );
        end
    endgenerate

    // Rotating priority search starting at ptr; scanning from the far end
    // lets the nearest requester overwrite earlier hits.
    always_comb begin
        logic [ID_WIDTH-1:0] idx;
        grant_vld = 1'b0;
        grant_id  = '0;
        idx       = '0;
        for (int k = N - 1; k >= 0; k--) begin
            idx = ID_WIDTH'((int'(ptr) + k) % N);
            if (req[idx]) begin
                grant_vld = 1'b1;
                grant_id  = idx;
            end
        end
    end

    // Payload and last-flag mux for the winning source.
    always_comb begin
        win_data = '0;
        win_last = 1'b1;
        for (int i = 0; i < N; i++) begin
            if (grant_id == ID_WIDTH'(i)) begin
                win_data = s_data[i*DATA_WIDTH +: DATA_WIDTH];
`ifdef RV_ARB_LOCK_EN
                win_last = s_last[i];
`endif
            end
        end
    end

    // Pointer moves one past the winner, wrapping at N-1.
    assign nxt_ptr = (int'(grant_id) == N - 1) ? '0 : grant_id + 1'b1;

`ifdef RV_ARB_LOCK_EN
    // Output buffer, priority pointer and packet lock.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            m_valid <= 1'b0;
            m_data  <= '0;
            m_id    <= '0;
            m_last  <= 1'b0;
            ptr     <= '0;
            locked  <= 1'b0;
        end else if (load) begin
            if (grant_vld) begin
                m_valid <= 1'b1;
                m_data  <= win_data;
                m_id    <= grant_id;
                m_last  <= win_last;
                locked  <= !win_last;
                if (win_last) ptr <= nxt_ptr;
            end else begin
                m_valid <= 1'b0;
            end
        end
    end
`else
    assign locked = 1'b0;

    // Output buffer and priority pointer; every beat arbitrates alone.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            m_valid <= 1'b0;
            m_data  <= '0;
            m_id    <= '0;
            ptr     <= '0;
        end else if (load) begin
            if (grant_vld) begin
                m_valid <= 1'b1;
                m_data  <= win_data;
                m_id    <= grant_id;
                ptr     <= nxt_ptr;
            end else begin
                m_valid <= 1'b0;
            end
        end
    end

    // Last flag only matters with the lock feature.
    logic unused_last;
    assign unused_last = win_last;
`endif

endmodule

// File: tb/tb_rv_rr_arbiter.sv
// tb_rv_rr_arbiter: directed vectors for rv_rr_arbiter with N=4, 8-bit data.
// A scoreboard monitor checks every output beat against the accepted beats.
// Packet-lock vectors run when RV_ARB_LOCK_EN is defined.
module tb_rv_rr_arbiter;
    localparam int N  = 4;
    localparam int DW = 8;

    logic          clk = 1'b0;
    logic          resetn;
    logic [N-1:0]  s_valid;
    logic [N*DW-1:0] s_data;
    logic [N-1:0]  s_ready;
    logic          m_valid;
    logic [DW-1:0] m_data;
    logic [1:0]    m_id;
    logic          m_ready;
`ifdef RV_ARB_LOCK_EN
    logic [N-1:0]  s_last;
    logic          m_last;
`endif

    int n_chk  = 0;
    int n_fail = 0;
    int hs_cnt = 0;
    int out_cnt = 0;
    logic [DW-1:0] sb[$];

    rv_rr_arbiter #(.N(N), .DATA_WIDTH(DW)) dut (
        .clk     (clk),
        .resetn  (resetn),
        .s_valid (s_valid),
        .s_data  (s_data),
`ifdef RV_ARB_LOCK_EN
        .s_last  (s_last),
        .m_last  (m_last),
`endif
        .s_ready (s_ready),
        .m_valid (m_valid),
        .m_data  (m_data),
        .m_id    (m_id),
        .m_ready (m_ready)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_data(input int i, input logic [DW-1:0] v);
        s_data[i*DW +: DW] = v;
    endtask

    // Scoreboard: outputs must replay accepted beats in order, once each.
    always @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            sb.delete();
        end else begin
            if (m_valid && m_ready) begin
                out_cnt++;
                if (sb.size() == 0) chk("sb_underflow", 32'd1, 32'd0);
                else chk("sb_data", m_data, sb.pop_front());
            end
            for (int i = 0; i < N; i++)
                if (s_valid[i] && s_ready[i]) begin
                    hs_cnt++;
                    sb.push_back(s_data[i*DW +: DW]);
                end
        end
    end

    // Global time limit.
    initial begin
        #200000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1, "timeout");
    end

    initial begin
        logic [7:0] exp_d [4];
        logic [1:0] exp_i [4];
        logic [3:0] exp_r [4];
        logic       sv_pat [8];
        int hs0, out0;
        exp_d = '{8'hA0, 8'hB1, 8'hA0, 8'hB1};
        exp_i = '{2'd0, 2'd1, 2'd0, 2'd1};
        exp_r = '{4'b0001, 4'b0010, 4'b0001, 4'b0010};
        sv_pat = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1};

        resetn  = 1'b0;
        s_valid = '0;
        s_data  = '0;
        m_ready = 1'b0;
`ifdef RV_ARB_LOCK_EN
        s_last  = '1;
`endif
        repeat (2) tick();
        chk("rst_m_valid", m_valid, 0);
        chk("rst_m_data", m_data, 0);
        chk("rst_m_id", m_id, 0);
        chk("rst_s_ready", s_ready, 0);
        resetn = 1'b1;
        tick();

        // Two sources continuously valid: strict alternation.
        set_data(0, 8'hA0);
        set_data(1, 8'hB1);
        s_valid = 4'b0011;
        m_ready = 1'b1;
        for (int j = 0; j < 4; j++) begin
            #1 chk("alt_s_ready", s_ready, exp_r[j]);
            tick();
            chk("alt_m_valid", m_valid, 1);
            chk("alt_m_data", m_data, exp_d[j]);
            chk("alt_m_id", m_id, exp_i[j]);
        end
        s_valid = '0;
        tick();
        chk("alt_drain", m_valid, 0);

        // Stall: single source, downstream not ready for 3 cycles.
        set_data(2, 8'h55);
        s_valid = 4'b0100;
        m_ready = 1'b0;
        hs0 = hs_cnt;
        #1 chk("stall_first_ready", s_ready, 4'b0100);
        tick();
        for (int j = 0; j < 3; j++) begin
            chk("stall_s_ready", s_ready, 4'b0000);
            chk("stall_m_valid", m_valid, 1);
            chk("stall_m_data", m_data, 8'h55);
            chk("stall_m_id", m_id, 2);
            if (j < 2) tick();
        end
        s_valid = '0;
        m_ready = 1'b1;
        tick();
        chk("stall_drain", m_valid, 0);
        chk("stall_handshakes", hs_cnt - hs0, 1);

        // ptr=3 after grant to 2: wrap to 0, then 1.
        s_valid = 4'b0011;
        #1 chk("wrap_ready0", s_ready, 4'b0001);
        tick();
        chk("wrap_id0", m_id, 0);
        chk("wrap_data0", m_data, 8'hA0);
        chk("wrap_ready1", s_ready, 4'b0010);
        tick();
        chk("wrap_id1", m_id, 1);
        s_valid = '0;
        tick();

        // Reset while a beat is stalled in the buffer.
        set_data(2, 8'h77);
        s_valid = 4'b0100;
        m_ready = 1'b0;
        tick();
        chk("pre_rst_m_valid", m_valid, 1);
        chk("pre_rst_m_id", m_id, 2);
        s_valid = '0;
        #2 resetn = 1'b0;
        #1 chk("async_rst_m_valid", m_valid, 0);
        chk("async_rst_m_id", m_id, 0);
        tick();
        resetn = 1'b1;
        for (int i = 0; i < N; i++) set_data(i, 8'h11 * (i + 1));
        s_valid = 4'b1111;
        m_ready = 1'b1;
        #1 chk("post_rst_ready", s_ready, 4'b0001);
        tick();
        chk("post_rst_id", m_id, 0);
        chk("post_rst_data", m_data, 8'h11);
        s_valid = '0;
        tick();

        // Requester 1 valid toggling against toggling m_ready.
        hs0  = hs_cnt;
        out0 = out_cnt;
        for (int j = 0; j < 8; j++) begin
            set_data(1, 8'h10 + 8'(j));
            s_valid = {2'b00, sv_pat[j], 1'b0};
            m_ready = (j % 2 == 0);
            tick();
        end
        s_valid = '0;
        m_ready = 1'b1;
        repeat (2) tick();
        chk("tog_handshakes", hs_cnt - hs0, 3);
        chk("tog_outputs", out_cnt - out0, 3);
        chk("tog_sb_empty", sb.size(), 0);

`ifdef RV_ARB_LOCK_EN
        // Packet lock: source 0 sends 3 beats while source 1 waits.
        resetn = 1'b0;
        tick();
        resetn = 1'b1;
        set_data(1, 8'hD1);
        s_valid = 4'b0011;
        s_last  = 4'b0010;
        m_ready = 1'b1;
        for (int j = 0; j < 3; j++) begin
            set_data(0, 8'hC0 + 8'(j));
            s_last[0] = (j == 2);
            #1 chk("lock_ready", s_ready, 4'b0001);
            tick();
            chk("lock_id", m_id, 0);
            chk("lock_data", m_data, 8'hC0 + 8'(j));
            chk("lock_last", m_last, (j == 2));
        end
        #1 chk("unlock_ready", s_ready, 4'b0010);
        tick();
        chk("unlock_id", m_id, 1);
        chk("unlock_last", m_last, 1);
        s_valid = '0;
        tick();
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
